mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS control FSM; the initiator side of the ALU interface.
- Decodes opcode/funct and drives the 4-bit ALU operation code, operand selects, memory handshake and register/PC write enables.
- Consumes the ALU's ze/ovf flags to resolve branches and overflow traps.
- Sits between the instruction register and the datapath (ALU, register file, memory port).

Parameters:
- EXC_VEC_SEL, 2'd3: pc_src value that selects the exception vector.
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26]; valid from DECODE onward.
- funct  in  6  instruction[5:0].
- alu_ze  in  1  ALU zero flag; combinational, same cycle as alu_ctrl.
- alu_ovf  in  1  ALU signed-overflow flag.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_ctrl  out  4  0 AND, 1 OR, 2 ADD, 3 SLT, 4 ADDU, 5 SLL, 6 SUB, 7 SLTU.
- alusrc_a  out  1  0 PC, 1 rs.
- alusrc_b  out  2  0 rt, 1 const 4, 2 sign-extended imm, 3 imm<<2.
- iord  out  1  memory address from ALUOut (1) or PC (0).
- mem_read, mem_write  out  1 each  memory request, held until mem_ready.
- ir_write  out  1  latch the instruction.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1 rd, 0 rt.
- mem_to_reg  out  1  write-back source is MDR.
- pc_write  out  1  unconditional PC load.
- pc_src  out  2  0 ALU, 1 ALUOut, 2 jump target, 3 exception vector.
- exc  out  1  one-cycle trap pulse.
- exc_cause  out  2  0 none, 1 overflow, 2 reserved instruction; held until the next trap.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; every output 0; retired 0; exc_cause 0. Reset mid-instruction aborts it with no write.
- Outputs are decoded combinationally from the state register (and opcode in EXEC/BRANCH). exc_cause and retired are registered.
- IDLE: one cycle after reset release, then FETCH.
- FETCH: mem_read=1, iord=0. On mem_ready: ir_write=1, PC <- PC+4 (alusrc_a=0, alusrc_b=1, alu_ctrl=4, pc_write=1), go to DECODE. Otherwise stay in FETCH with outputs held, no writes.
- DECODE: ALUOut <- PC + (imm<<2) (alu_ctrl=4, alusrc_b=3). Dispatch:
  - lw/sw (0x23/0x2B) -> MEMADR
  - R-type (0x00) -> EXEC
  - beq/bne (0x04/0x05) -> BRANCH
  - j (0x02) -> JUMP
  - addi/addiu/slti/sltiu/andi/ori (0x08/09/0A/0B/0C/0D) -> EXEC
  - anything else -> TRAP, cause 2
- MEMADR: alu_ctrl=4, alusrc_b=2. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEMWR: mem_write=1, iord=1; wait for mem_ready, then FETCH.
- EXEC, R-type funct map: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUB (overflow ignored), 0x24 AND, 0x25 OR, 0x2A SLT, 0x2B SLTU, 0x00 SLL. Unknown funct -> TRAP, cause 2.
- EXEC, I-type map: addi ADD, addiu ADDU, slti SLT, sltiu SLTU, andi AND, ori OR; alusrc_b=2.
- EXEC exit: if the op is add, sub or addi and alu_ovf=1 -> TRAP, cause 1. Otherwise -> WB.
- WB: reg_write=1, reg_dst=1 for R-type else 0, then FETCH.
- BRANCH: alu_ctrl=6, alusrc_a=1, alusrc_b=0, pc_src=1. pc_write=1 iff (beq and alu_ze) or (bne and !alu_ze). Then FETCH.
- JUMP: pc_src=2, pc_write=1, then FETCH.
- TRAP: exc=1, pc_src=EXC_VEC_SEL, pc_write=1, reg_write=0, then FETCH.
- retired increments on entry to FETCH from MEMWB, MEMWR, WB, BRANCH, JUMP or TRAP. It wraps modulo 2^RETIRE_W.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro MIPS_MC_CTRL_TRAP_EN.
- Defined: overflow and reserved-instruction traps as described above.
- Undefined:
  - alu_ovf is ignored; add/sub/addi write back normally.
  - Unknown opcode/funct executes as a NOP (DECODE -> FETCH, counted as retired).
  - exc and exc_cause are tied to 0; the TRAP state is not built.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALU ctrl codes (ALU_AND..ALU_SLTU)
  - opcode and funct constants
  - state enumeration
  - pc_src and alusrc_b encodings
  - exc_cause codes
- Sub-module alu_ctrl_dec: combinational {state-class, opcode, funct} -> {alu_ctrl, ovf_check, illegal}.

Test Plan:
- Reset: hold rst_n=0, release -> one IDLE cycle with all outputs 0, then mem_read=1 in FETCH.
- Fetch stall: mem_ready low 3 cycles -> FETCH held, ir_write=0; ready -> ir_write=1 and pc_write=1 for exactly one cycle.
- add with overflow: R-type funct 0x20, alu_ovf=1 in EXEC -> alu_ctrl=2, reg_write never 1, exc pulse, exc_cause=1, pc_src=3. addu (0x21) with alu_ovf=1 -> reg_write=1, no exc.
- beq/bne: beq with alu_ze=1 -> pc_write=1, pc_src=1; alu_ze=0 -> pc_write=0. bne gives the inverse result.
- lw: 0x23 -> MEMADR alu_ctrl=4; MEMRD waits 2 cycles for mem_ready; MEMWB reg_write=1, mem_to_reg=1; retired +1.
- Illegal opcode 0x3F -> exc_cause=2 with the macro defined; NOP with no exc when the macro is undefined.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: ALU codes, opcodes,
// funct values, FSM states and the select/cause encodings it drives.
package mips_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_ADDU = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OVF  = 2'd1;
    localparam logic [1:0] CAUSE_RI   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    // What the ALU is being used for in the current state
    typedef enum logic [1:0] {CLS_NONE, CLS_ADDU, CLS_SUB, CLS_EXEC} alu_cls_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decode: maps the state class plus opcode/funct to an ALU code,
// flags ops whose signed overflow must trap, and flags unknown encodings.
module alu_ctrl_dec
    import mips_ctrl_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       ovf_check,
    output logic       illegal
);

    always_comb begin
        alu_ctrl  = ALU_AND;
        ovf_check = 1'b0;
        illegal   = 1'b0;
        case (cls)
            CLS_ADDU: alu_ctrl = ALU_ADDU;
            CLS_SUB:  alu_ctrl = ALU_SUB;
            CLS_EXEC: begin
                if (opcode == OP_RTYPE) begin
                    case (funct)
                        FN_ADD:  begin alu_ctrl = ALU_ADD; ovf_check = 1'b1; end
                        FN_ADDU: alu_ctrl = ALU_ADDU;
                        FN_SUB:  begin alu_ctrl = ALU_SUB; ovf_check = 1'b1; end
                        FN_SUBU: alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_SLT:  alu_ctrl = ALU_SLT;
                        FN_SLTU: alu_ctrl = ALU_SLTU;
                        FN_SLL:  alu_ctrl = ALU_SLL;
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    case (opcode)
                        OP_ADDI:  begin alu_ctrl = ALU_ADD; ovf_check = 1'b1; end
                        OP_ADDIU: alu_ctrl = ALU_ADDU;
                        OP_SLTI:  alu_ctrl = ALU_SLT;
                        OP_SLTIU: alu_ctrl = ALU_SLTU;
                        OP_ANDI:  alu_ctrl = ALU_AND;
                        OP_ORI:   alu_ctrl = ALU_OR;
                        default:  illegal = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM. Outputs decode from the state register.
// MIPS_MC_CTRL_TRAP_EN enables overflow / reserved-instruction traps.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [1:0] EXC_VEC_SEL = 2'd3,
    parameter int         RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_ze,
    input  logic                alu_ovf,
    input  logic                mem_ready,
    output logic [3:0]          alu_ctrl,
    output logic                alusrc_a,
    output logic [1:0]          alusrc_b,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                exc,
    output logic [1:0]          exc_cause,
    output logic [RETIRE_W-1:0] retired
);

    state_e   state, state_n;
    alu_cls_e cls;
    logic     ovf_check, illegal;

    always_comb begin
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: cls = CLS_ADDU;
            S_BRANCH:                    cls = CLS_SUB;
            S_EXEC:                      cls = CLS_EXEC;
            default:                     cls = CLS_NONE;
        endcase
    end

    alu_ctrl_dec u_dec (
        .cls       (cls),
        .opcode    (opcode),
        .funct     (funct),
        .alu_ctrl  (alu_ctrl),
        .ovf_check (ovf_check),
        .illegal   (illegal)
    );

`ifdef MIPS_MC_CTRL_TRAP_EN
    logic [1:0] cause_n;
`else
    logic unused_trap_in;
    assign unused_trap_in = ^{alu_ovf, ovf_check};
`endif

    always_comb begin
        state_n = state;
`ifdef MIPS_MC_CTRL_TRAP_EN
        cause_n = exc_cause;
`endif
        case (state)
            S_IDLE:   state_n = S_FETCH;
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:       state_n = S_MEMADR;
                    OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_SLTIU, OP_ANDI, OP_ORI: state_n = S_EXEC;
                    OP_BEQ, OP_BNE:     state_n = S_BRANCH;
                    OP_J:               state_n = S_JUMP;
`ifdef MIPS_MC_CTRL_TRAP_EN
                    default: begin state_n = S_TRAP; cause_n = CAUSE_RI; end
`else
                    default: state_n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_n = S_FETCH;
            S_EXEC: begin
`ifdef MIPS_MC_CTRL_TRAP_EN
                if (illegal) begin
                    state_n = S_TRAP; cause_n = CAUSE_RI;
                end else if (ovf_check && alu_ovf) begin
                    state_n = S_TRAP; cause_n = CAUSE_OVF;
                end else begin
                    state_n = S_WB;
                end
`else
                state_n = illegal ? S_FETCH : S_WB;
`endif
            end
            S_MEMWB, S_WB, S_BRANCH, S_JUMP, S_TRAP: state_n = S_FETCH;
            default: state_n = S_IDLE;
        endcase
    end

    // Every return to FETCH other than a fetch stall or the post-reset
    // IDLE cycle ends exactly one instruction (including NOP'd encodings).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            state <= state_n;
            if (state_n == S_FETCH && state != S_FETCH && state != S_IDLE)
                retired <= retired + 1'b1;
        end
    end

`ifdef MIPS_MC_CTRL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exc_cause <= CAUSE_NONE;
        else        exc_cause <= cause_n;
    end
`else
    assign exc_cause = CAUSE_NONE;
`endif

    always_comb begin
        alusrc_a   = 1'b0;
        alusrc_b   = SRCB_RT;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        exc        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: alusrc_b = SRCB_IMMSH;
            S_MEMADR: begin alusrc_a = 1'b1; alusrc_b = SRCB_IMM; end
            S_MEMRD:  begin mem_read = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            S_MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
            S_EXEC: begin
                alusrc_a = 1'b1;
                alusrc_b = (opcode == OP_RTYPE) ? SRCB_RT : SRCB_IMM;
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_RTYPE);
            end
            S_BRANCH: begin
                alusrc_a = 1'b1;
                pc_src   = PC_ALUOUT;
                pc_write = ((opcode == OP_BEQ) && alu_ze) ||
                           ((opcode == OP_BNE) && !alu_ze);
            end
            S_JUMP: begin pc_src = PC_JUMP; pc_write = 1'b1; end
`ifdef MIPS_MC_CTRL_TRAP_EN
            S_TRAP: begin exc = 1'b1; pc_src = EXC_VEC_SEL; pc_write = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: reset, fetch stall, ALU ops with overflow,
// branches, loads/stores, illegal opcode (both MIPS_MC_CTRL_TRAP_EN builds).
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_ze, alu_ovf, mem_ready;
    logic [3:0]  alu_ctrl;
    logic        alusrc_a;
    logic [1:0]  alusrc_b;
    logic        iord, mem_read, mem_write, ir_write, reg_write, reg_dst;
    logic        mem_to_reg, pc_write, exc;
    logic [1:0]  pc_src, exc_cause;
    logic [15:0] retired;

    int n_chk = 0;
    int n_err = 0;
    int exp_ret = 0;

    mips_mc_ctrl #(.EXC_VEC_SEL(2'd3), .RETIRE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_ze(alu_ze), .alu_ovf(alu_ovf), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
        .exc(exc), .exc_cause(exc_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {alu_ctrl, alusrc_a, alusrc_b, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, pc_write, pc_src, exc, exc_cause};
    endfunction

    // Advance to the next negedge, drive inputs, settle, then caller checks
    task automatic step(input logic rdy, input logic ovf, input logic ze);
        @(negedge clk);
        mem_ready = rdy; alu_ovf = ovf; alu_ze = ze;
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        mem_ready = 1'b1; alu_ovf = 1'b0; alu_ze = 1'b0;
        opcode = op; funct = fn;
        #1;
        chk("fetch_irw", ir_write, 1);
        chk("fetch_pcw", pc_write, 1);
        chk("fetch_ret", retired, exp_ret);
    endtask

    task automatic branch(input logic [5:0] op, input logic ze, input logic taken);
        fetch(op, 6'h00);
        step(0, 0, 0);
        step(0, 0, ze);
        chk("br_alu", alu_ctrl, 6);
        chk("br_src", {alusrc_a, alusrc_b, pc_src}, {1'b1, 2'd0, 2'd1});
        chk("br_pcw", pc_write, taken);
        exp_ret++;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0;
        alu_ze = 1'b0; alu_ovf = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", all_outs(), 0);
        chk("rst_ret", retired, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_outs", all_outs(), 0);

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk("stall_rd", {mem_read, iord}, 2'b10);
            chk("stall_wr", {ir_write, pc_write}, 2'b00);
        end

        // add overflowing
        fetch(6'h00, 6'h20);
        chk("fetch_alu", {alu_ctrl, alusrc_a, alusrc_b}, {4'd4, 1'b0, 2'd1});
        step(0, 0, 0);
        chk("dec_alu", {alu_ctrl, alusrc_b}, {4'd4, 2'd3});
        chk("dec_wr", {ir_write, pc_write}, 2'b00);
        step(0, 1, 0);
        chk("add_alu", alu_ctrl, 2);
        chk("add_rw", reg_write, 0);
        step(0, 0, 0);
`ifdef MIPS_MC_CTRL_TRAP_EN
        chk("ovf_exc", {exc, exc_cause, pc_src, pc_write}, {1'b1, 2'd1, 2'd3, 1'b1});
        chk("ovf_rw", reg_write, 0);
`else
        chk("ovf_wb", {reg_write, reg_dst, exc}, 3'b110);
`endif
        exp_ret++;

        // addu overflowing writes back normally
        fetch(6'h00, 6'h21);
        step(0, 0, 0);
        step(0, 1, 0);
        chk("addu_alu", alu_ctrl, 4);
        step(0, 0, 0);
        chk("addu_wb", {reg_write, reg_dst, exc}, 3'b110);
        exp_ret++;

        branch(6'h04, 1, 1);
        branch(6'h04, 0, 0);
        branch(6'h05, 1, 0);
        branch(6'h05, 0, 1);

        // lw with a two-cycle memory wait
        fetch(6'h23, 6'h00);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("madr", {alu_ctrl, alusrc_a, alusrc_b}, {4'd4, 1'b1, 2'd2});
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            chk("lw_wait", {mem_read, mem_write, iord, reg_write}, 4'b1010);
        end
        step(1, 0, 0);
        chk("lw_rdy", {mem_read, iord}, 2'b11);
        step(0, 0, 0);
        chk("lw_wb", {reg_write, mem_to_reg, reg_dst}, 3'b110);
        exp_ret++;

        fetch(6'h2B, 6'h00);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("sw_mem", {mem_read, mem_write, iord, reg_write}, 4'b0110);
        exp_ret++;

        // illegal opcode
        fetch(6'h3F, 6'h00);
        step(0, 0, 0);
`ifdef MIPS_MC_CTRL_TRAP_EN
        step(0, 0, 0);
        chk("ri_exc", {exc, exc_cause, pc_src, pc_write}, {1'b1, 2'd2, 2'd3, 1'b1});
`endif
        exp_ret++;

        fetch(6'h02, 6'h00);
        chk("nop_exc", exc, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("jump", {pc_src, pc_write}, {2'd2, 1'b1});
        exp_ret++;

        fetch(6'h23, 6'h00);
`ifdef MIPS_MC_CTRL_TRAP_EN
        chk("cause_held", exc_cause, 2);
`else
        chk("cause_tied", exc_cause, 0);
`endif
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mid_rd", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", all_outs(), 0);
        chk("mid_rst_ret", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("post_rst_fetch", {mem_read, iord}, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
